wordle_board_renderer: RTL and testbench

- Read-side consumer of the Wordle board store. The scoring logic writes the board; this block reads it back.
- Per pixel, maps CounterX/CounterY from hvsync_generator to one of 6x5 letter tiles.
- Fetches that tile's {letter, color} word from the board memory read port, then looks up the glyph in a font ROM.
- Drives registered vga_r/g/b, plus vga_h_sync/vga_v_sync delayed to stay aligned with the colour pipeline. Includes a frame-counted blinking cursor on the tile being typed.

---
 rtl/wordle_pkg.sv | 22 ++
 rtl/wordle_font_rom.sv | 61 ++++++
 rtl/wordle_board_renderer.sv | 191 +++++++++++++++++++
 tb/tb_wordle_board_renderer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wordle_pkg.sv
// Shared constants and helpers for the Wordle board display path.
package wordle_pkg;

  localparam int NUM_ROWS = 6;
  localparam int NUM_COLS = 5;
  localparam int PIPE_LAT = 4;

  typedef logic [2:0] rgb_t;

  localparam rgb_t COLOR_WHITE  = 3'b111;
  localparam rgb_t COLOR_GREEN  = 3'b010;
  localparam rgb_t COLOR_YELLOW = 3'b110;
  localparam rgb_t COLOR_BLACK  = 3'b000;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  function automatic logic [4:0] tile_index(input logic [2:0] row, input logic [2:0] col);
    tile_index = ({2'b00, row} * 5'(NUM_COLS)) + {2'b00, col};
  endfunction

endpackage

// File: rtl/wordle_font_rom.sv
// 8x8 uppercase font, address {glyph[4:0], row[2:0]}, one-cycle registered read.
module wordle_font_rom
  import wordle_pkg::*;
(
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] addr,
  output logic [7:0] row_data
);

  logic [63:0] glyph_s;
  logic [7:0]  row_s;

  // Glyph table, top row in the most significant byte; leftmost pixel is bit 7
  always_comb begin
    case (addr[7:3])
      5'd0:    glyph_s = 64'h183C66667E666600;
      5'd1:    glyph_s = 64'h7C66667C66667C00;
      5'd2:    glyph_s = 64'h3C66606060663C00;
      5'd3:    glyph_s = 64'h786C6666666C7800;
      5'd4:    glyph_s = 64'h7E6060786060_7E00;
      5'd5:    glyph_s = 64'h7E60607860606000;
      5'd6:    glyph_s = 64'h3C66606E66663C00;
      5'd7:    glyph_s = 64'h6666667E66666600;
      5'd8:    glyph_s = 64'h3C18181818183C00;
      5'd9:    glyph_s = 64'h1E0C0C0C0C6C3800;
      5'd10:   glyph_s = 64'h666C7870786C6600;
      5'd11:   glyph_s = 64'h6060606060607E00;
      5'd12:   glyph_s = 64'h63777F6B63636300;
      5'd13:   glyph_s = 64'h66767E7E6E666600;
      5'd14:   glyph_s = 64'h3C66666666663C00;
      5'd15:   glyph_s = 64'h7C66667C60606000;
      5'd16:   glyph_s = 64'h3C666666663C0E00;
      5'd17:   glyph_s = 64'h7C66667C786C6600;
      5'd18:   glyph_s = 64'h3C66603C06663C00;
      5'd19:   glyph_s = 64'h7E18181818181800;
      5'd20:   glyph_s = 64'h6666666666663C00;
      5'd21:   glyph_s = 64'h66666666663C1800;
      5'd22:   glyph_s = 64'h6363636B7F776300;
      5'd23:   glyph_s = 64'h66663C183C666600;
      5'd24:   glyph_s = 64'h6666663C18181800;
      5'd25:   glyph_s = 64'h7E060C1830607E00;
      default: glyph_s = 64'h0000000000000000;
    endcase
  end

  // Row 0 sits in bits [63:56], so the byte offset is (7-row)*8
  always_comb begin
    row_s = glyph_s[{~addr[2:0], 3'b000} +: 8];
  end

  // Registered read port
  always_ff @(posedge Clk) begin
    if (!reset) begin
      row_data <= 8'h00;
    end else begin
      row_data <= row_s;
    end
  end

endmodule

// File: rtl/wordle_board_renderer.sv
// Renders the 6x5 Wordle board: tile decode, board read, glyph lookup, colour mux,
// with sync signals delayed to match the four-stage pixel pipeline.
module wordle_board_renderer
  import wordle_pkg::*;
#(
  parameter int X0           = 224,
  parameter int Y0           = 8,
  parameter int TILE         = 40,
  parameter int PITCH        = 48,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [9:0]  CounterX,
  input  logic [9:0]  CounterY,
  input  logic        inDisplayArea,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic [10:0] rd_data,
  input  logic [2:0]  cur_row,
  input  logic [2:0]  cur_col,
  input  logic        cursor_en,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        vga_h_sync,
  output logic        vga_v_sync
);

  logic       hit_x_s, hit_y_s, in_x_s, in_y_s, tile_hit_s, cm_s;
  logic [2:0] col_s, row_s;
  logic [5:0] ox_s, oy_s;
  logic [9:0] lo_x_s, lo_y_s;

  logic       v1_r, cm1_r, v2_r, cm2_r, v3_r, cm3_r, edge3_r, border3_r, glyph3_r;
  logic [5:0] ox1_r, oy1_r, ox2_r, oy2_r;
  rgb_t       color2_r, color3_r, pix_s;

  logic [7:0] letter_s, font_addr_s, font_row_s;
  logic       is_letter_s, edge_s, border_s, win_s, glyph_s;
  logic [4:0] glyph_idx_s;
  logic [2:0] gcol_s;

  logic [PIPE_LAT-1:0] hs_pipe_r, vs_pipe_r;
  logic                vs_prev_r, blink_on_r;
  logic [4:0]          blink_cnt_r;

  // Constant compare chain per axis; at most one column and one row can match
  always_comb begin
    hit_x_s = 1'b0; col_s = 3'd0; ox_s = 6'd0; lo_x_s = 10'd0; in_x_s = 1'b0;
    hit_y_s = 1'b0; row_s = 3'd0; oy_s = 6'd0; lo_y_s = 10'd0; in_y_s = 1'b0;
    for (int c = 0; c < NUM_COLS; c++) begin
      lo_x_s  = 10'(X0 + c * PITCH);
      in_x_s  = (CounterX >= lo_x_s) && (CounterX < lo_x_s + 10'(TILE));
      hit_x_s = hit_x_s | in_x_s;
      col_s   = in_x_s ? 3'(c) : col_s;
      ox_s    = in_x_s ? 6'(CounterX - lo_x_s) : ox_s;
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      lo_y_s  = 10'(Y0 + r * PITCH);
      in_y_s  = (CounterY >= lo_y_s) && (CounterY < lo_y_s + 10'(TILE));
      hit_y_s = hit_y_s | in_y_s;
      row_s   = in_y_s ? 3'(r) : row_s;
      oy_s    = in_y_s ? 6'(CounterY - lo_y_s) : oy_s;
    end
    tile_hit_s = hit_x_s & hit_y_s;
    cm_s       = cursor_en && (cur_row == row_s) && (cur_col == col_s);
  end

  // S1: tile decode registers and board read request
  always_ff @(posedge Clk) begin
    if (!reset) begin
      v1_r <= 1'b0; cm1_r <= 1'b0; ox1_r <= 6'd0; oy1_r <= 6'd0;
      rd_en <= 1'b0; rd_addr <= 5'd0;
    end else begin
      v1_r    <= tile_hit_s & inDisplayArea;
      cm1_r   <= cm_s;
      ox1_r   <= ox_s;
      oy1_r   <= oy_s;
      rd_en   <= tile_hit_s & inDisplayArea;
      rd_addr <= tile_hit_s ? tile_index(row_s, col_s) : 5'd0;
    end
  end

  // Non-letters (and idle slots) point at glyph 31, which the ROM leaves blank
  always_comb begin
    letter_s    = rd_data[10:3];
    is_letter_s = v1_r && (letter_s >= ASCII_A) && (letter_s <= ASCII_Z);
    glyph_idx_s = is_letter_s ? 5'(letter_s - ASCII_A) : 5'd31;
    font_addr_s = {glyph_idx_s, 3'((oy1_r - 6'd4) >> 2)};
  end

  wordle_font_rom u_font (
    .Clk      (Clk),
    .reset    (reset),
    .addr     (font_addr_s),
    .row_data (font_row_s)
  );

  // S2: capture board colour alongside the outstanding font read
  always_ff @(posedge Clk) begin
    if (!reset) begin
      v2_r <= 1'b0; cm2_r <= 1'b0; ox2_r <= 6'd0; oy2_r <= 6'd0; color2_r <= COLOR_BLACK;
    end else begin
      v2_r     <= v1_r;
      cm2_r    <= cm1_r;
      ox2_r    <= ox1_r;
      oy2_r    <= oy1_r;
      color2_r <= v1_r ? rd_data[2:0] : COLOR_BLACK;
    end
  end

  // Glyph is drawn 4x scaled in the 32x32 window centred in the tile
  always_comb begin
    gcol_s   = 3'((ox2_r - 6'd4) >> 2);
    win_s    = (ox2_r >= 6'd4) && (ox2_r < 6'd36) && (oy2_r >= 6'd4) && (oy2_r < 6'd36);
    glyph_s  = win_s && font_row_s[3'd7 - gcol_s];
    edge_s   = (ox2_r == 6'd0) || (ox2_r == 6'(TILE - 1)) ||
               (oy2_r == 6'd0) || (oy2_r == 6'(TILE - 1));
    border_s = (ox2_r < 6'd2) || (ox2_r >= 6'(TILE - 2)) ||
               (oy2_r < 6'd2) || (oy2_r >= 6'(TILE - 2));
  end

  // S3: per-pixel attributes ready for the colour mux
  always_ff @(posedge Clk) begin
    if (!reset) begin
      v3_r <= 1'b0; cm3_r <= 1'b0; edge3_r <= 1'b0; border3_r <= 1'b0;
      glyph3_r <= 1'b0; color3_r <= COLOR_BLACK;
    end else begin
      v3_r      <= v2_r;
      cm3_r     <= cm2_r;
      edge3_r   <= edge_s;
      border3_r <= border_s;
      glyph3_r  <= glyph_s;
      color3_r  <= color2_r;
    end
  end

  // Colour priority: blank, cursor border, unscored outline, glyph, tile fill
  always_comb begin
    if (!v3_r) begin
      pix_s = COLOR_BLACK;
    end else if (cm3_r && blink_on_r && border3_r) begin
      pix_s = COLOR_YELLOW;
    end else if ((color3_r == COLOR_BLACK) && edge3_r) begin
      pix_s = COLOR_WHITE;
    end else if (glyph3_r) begin
      pix_s = (color3_r != COLOR_BLACK) ? COLOR_BLACK : COLOR_WHITE;
    end else begin
      pix_s = color3_r;
    end
  end

  // S4: registered colour outputs and sync delay lines
  always_ff @(posedge Clk) begin
    if (!reset) begin
      {vga_r, vga_g, vga_b} <= 3'b000;
      hs_pipe_r <= '0;
      vs_pipe_r <= '0;
    end else begin
      {vga_r, vga_g, vga_b} <= pix_s;
      hs_pipe_r <= {hs_pipe_r[PIPE_LAT-2:0], h_sync_in};
      vs_pipe_r <= {vs_pipe_r[PIPE_LAT-2:0], v_sync_in};
    end
  end

  assign vga_h_sync = hs_pipe_r[PIPE_LAT-1];
  assign vga_v_sync = vs_pipe_r[PIPE_LAT-1];

  // Cursor blink: count vsync falling edges, toggle on exact wrap
  always_ff @(posedge Clk) begin
    if (!reset) begin
      vs_prev_r <= 1'b0; blink_cnt_r <= 5'd0; blink_on_r <= 1'b0;
    end else begin
      vs_prev_r <= v_sync_in;
      if (vs_prev_r && !v_sync_in) begin
        if (blink_cnt_r == 5'(BLINK_FRAMES - 1)) begin
          blink_cnt_r <= 5'd0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + 5'd1;
        end
      end else begin
        blink_cnt_r <= blink_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_wordle_board_renderer.sv
// Table-driven bench: expected pixels and syncs go into a scoreboard queue at drive time
// and are popped when the four-cycle pipeline delivers them.
module tb_wordle_board_renderer;
  import wordle_pkg::*;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  CounterX = 10'd0, CounterY = 10'd0;
  logic        inDisplayArea = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic        rd_en;
  logic [4:0]  rd_addr;
  logic [10:0] rd_data;
  logic [2:0]  cur_row = 3'd0, cur_col = 3'd0;
  logic        cursor_en = 1'b0;
  logic        vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync;

  logic [10:0] board [0:29];
  assign rd_data = (rd_addr < 5'd30) ? board[rd_addr] : 11'h000;

  wordle_board_renderer #(.BLINK_FRAMES(2)) dut (
    .Clk(Clk), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
    .inDisplayArea(inDisplayArea), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .cur_row(cur_row), .cur_col(cur_col), .cursor_en(cursor_en),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
    logic [2:0] crow;
    logic [2:0] ccol;
    logic       cen;
    logic [2:0] rgb;
    logic       ren;
    logic [4:0] addr;
  } vec_t;

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    int         id;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0, n_fail = 0, step_no = 0;
  logic       pend_valid = 1'b0, pend_ren = 1'b0;
  logic [4:0] pend_addr = 5'd0;
  vec_t       tbl [18];

  function automatic vec_t mk(input int x, input int y, input logic de, input logic hs,
                              input logic vs, input int crow, input int ccol, input logic cen,
                              input logic [2:0] rgb, input logic ren, input int addr);
    vec_t v;
    v.x = 10'(x); v.y = 10'(y); v.de = de; v.hs = hs; v.vs = vs;
    v.crow = 3'(crow); v.ccol = 3'(ccol); v.cen = cen;
    v.rgb = rgb; v.ren = ren; v.addr = 5'(addr);
    return v;
  endfunction

  function automatic vec_t idle(input logic hs, input logic vs);
    return mk(0, 0, 1'b0, hs, vs, 0, 0, 1'b0, 3'b000, 1'b0, 0);
  endfunction

  task automatic step(input logic rst_v, input vec_t v);
    exp_t e;
    @(negedge Clk);
    if (exp_q.size() == PIPE_LAT) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({vga_r, vga_g, vga_b} !== e.rgb) begin
        n_fail++;
        $display("FAIL rgb step %0d: got %b expected %b", e.id, {vga_r, vga_g, vga_b}, e.rgb);
      end
      n_tests++;
      if ({vga_h_sync, vga_v_sync} !== {e.hs, e.vs}) begin
        n_fail++;
        $display("FAIL sync step %0d: got %b expected %b", e.id,
                 {vga_h_sync, vga_v_sync}, {e.hs, e.vs});
      end
    end
    if (pend_valid) begin
      n_tests++;
      if ({rd_en, rd_addr} !== {pend_ren, pend_addr}) begin
        n_fail++;
        $display("FAIL rd step %0d: got en=%b addr=%0d expected en=%b addr=%0d",
                 step_no - 1, rd_en, rd_addr, pend_ren, pend_addr);
      end
    end
    reset = rst_v;
    CounterX = v.x; CounterY = v.y; inDisplayArea = v.de;
    h_sync_in = v.hs; v_sync_in = v.vs;
    cur_row = v.crow; cur_col = v.ccol; cursor_en = v.cen;
    pend_valid = 1'b1;
    if (!rst_v) begin
      // reset flushes everything still in flight
      for (int i = 0; i < exp_q.size(); i++) begin
        exp_q[i].rgb = 3'b000; exp_q[i].hs = 1'b0; exp_q[i].vs = 1'b0;
      end
      exp_q.push_back('{rgb: 3'b000, hs: 1'b0, vs: 1'b0, id: step_no});
      pend_ren = 1'b0; pend_addr = 5'd0;
    end else begin
      exp_q.push_back('{rgb: v.rgb, hs: v.hs, vs: v.vs, id: step_no});
      pend_ren = v.ren; pend_addr = v.addr;
    end
    step_no++;
  endtask

  initial begin
    for (int i = 0; i < 30; i++) board[i] = {8'h20, 3'b000};
    board[0]  = {8'h20, 3'b010};
    board[7]  = {8'h42, 3'b000};
    board[11] = {8'h43, 3'b010};
    board[12] = {8'h54, 3'b010};
    board[13] = {8'h61, 3'b000};
    board[29] = {8'h41, 3'b110};

    tbl[0]  = mk(224,   8, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 0);
    tbl[1]  = mk(432, 264, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b110, 1'b1, 29);
    tbl[2]  = mk(428, 264, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b1, 29);
    tbl[3]  = mk(100, 100, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 0);
    tbl[4]  = mk(432, 264, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 29);
    tbl[5]  = mk(320,  56, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b111, 1'b1, 7);
    tbl[6]  = mk(359,  76, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b111, 1'b1, 7);
    tbl[7]  = mk(328,  60, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b111, 1'b1, 7);
    tbl[8]  = mk(324,  60, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b1, 7);
    tbl[9]  = mk(328, 108, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b1, 12);
    tbl[10] = mk(356, 124, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 12);
    tbl[11] = mk(384, 108, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b1, 13);
    tbl[12] = mk(264,   8, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 0);
    tbl[13] = mk(263,   8, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 0);
    tbl[14] = mk(224,  47, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 0);
    tbl[15] = mk(224,  48, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 0);
    tbl[16] = mk(224, 288, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 0);
    tbl[17] = mk(223,   8, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 0);

    // power-on reset with an active tile pixel and syncs high
    for (int i = 0; i < 3; i++) step(1'b0, mk(224, 8, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b000, 1'b0, 0));
    for (int i = 0; i < 4; i++) step(1'b1, idle(1'b1, 1'b1));

    foreach (tbl[i]) step(1'b1, tbl[i]);
    for (int i = 0; i < 4; i++) step(1'b1, idle(1'(i), 1'b1));

    // blink: cursor on tile (2,1) stays plain until two vsync falls
    step(1'b1, mk(272, 104, 1'b1, 1'b0, 1'b1, 2, 1, 1'b1, 3'b010, 1'b1, 11));
    for (int i = 0; i < 4; i++) step(1'b1, idle(1'b0, 1'(i)));
    for (int i = 0; i < 4; i++) step(1'b1, idle(1'(i), 1'b1));
    step(1'b1, mk(272, 104, 1'b1, 1'b0, 1'b1, 2, 1, 1'b1, 3'b110, 1'b1, 11));
    step(1'b1, mk(272, 104, 1'b1, 1'b1, 1'b1, 2, 1, 1'b0, 3'b010, 1'b1, 11));
    step(1'b1, mk(272, 104, 1'b1, 1'b0, 1'b1, 6, 1, 1'b1, 3'b010, 1'b1, 11));
    step(1'b1, mk(272, 104, 1'b1, 1'b1, 1'b1, 2, 5, 1'b1, 3'b010, 1'b1, 11));
    step(1'b1, mk(310, 124, 1'b1, 1'b0, 1'b1, 2, 1, 1'b1, 3'b110, 1'b1, 11));
    step(1'b1, mk(292, 124, 1'b1, 1'b1, 1'b1, 2, 1, 1'b1, 3'b010, 1'b1, 11));
    for (int i = 0; i < 4; i++) step(1'b1, idle(1'b0, 1'(i)));
    for (int i = 0; i < 4; i++) step(1'b1, idle(1'b0, 1'b1));
    step(1'b1, mk(272, 104, 1'b1, 1'b1, 1'b1, 2, 1, 1'b1, 3'b010, 1'b1, 11));

    // reset mid-line while active pixels stream through
    for (int i = 0; i < 5; i++) step(1'b1, mk(240, 20, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 0));
    for (int i = 0; i < 2; i++) step(1'b0, mk(240, 20, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 0));
    for (int i = 0; i < 6; i++) step(1'b1, mk(240, 20, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 3'b010, 1'b1, 0));
    for (int i = 0; i < 5; i++) step(1'b1, idle(1'b0, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
